// File: rtl/hamming_pkg.sv
// Shared (15,11) Hamming constants, types and the data-position map.
// Used by both the serial encoder and the serial decoder.
package hamming_pkg;

    localparam int unsigned N = 15;
    localparam int unsigned K = 11;
    localparam int unsigned R = 4;

    typedef logic [N-1:0] codeword_t;  // bit p-1 holds codeword position p
    typedef logic [K-1:0] data_t;
    typedef logic [R-1:0] syndrome_t;

    typedef enum logic {StIdle, StRecv} rx_state_e;

    localparam logic [R-1:0] DataPos [K] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic logic [R-1:0] data_pos(input int unsigned k);
        return DataPos[k];
    endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Serial codeword input and corrected-data output bundle of the Hamming decoder.
interface hamming_decoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic                  s_in;
    logic                  s_valid;
    logic                  s_sof;
    logic                  s_out;
    logic                  s_out_valid;
    logic                  s_out_sof;
    hamming_pkg::syndrome_t syndrome;
    logic                  corrected;
    logic                  frame_abort;
    logic [CNT_W-1:0]      err_count;

    modport master (
        output s_in, s_valid, s_sof,
        input  s_out, s_out_valid, s_out_sof, syndrome, corrected, frame_abort, err_count
    );

    modport slave (
        input  s_in, s_valid, s_sof,
        output s_out, s_out_valid, s_out_sof, syndrome, corrected, frame_abort, err_count
    );

endinterface

// File: rtl/hamming_corrector.sv
// Combinational (15,11) syndrome computation and single-bit correction.
module hamming_corrector
    import hamming_pkg::*;
(
    input  codeword_t codeword,
    output syndrome_t syndrome,
    output data_t     data
);

    codeword_t fixed;

    always_comb begin
        syndrome = '0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (codeword[p-1]) begin
                syndrome ^= syndrome_t'(p);
            end
        end

        // A parity-position syndrome only touches a parity bit, so data is untouched.
        fixed = codeword;
        if (syndrome != '0) begin
            fixed[syndrome - 4'd1] = ~fixed[syndrome - 4'd1];
        end

        data = '0;
        for (int unsigned k = 0; k < K; k++) begin
            data[k] = fixed[data_pos(k) - 4'd1];
        end
    end

endmodule

// File: rtl/hamming_decoder.sv
// Serial (15,11) Hamming receive stage: deserialise, correct, re-serialise.
// Also counts corrected frames with a saturating counter.
module hamming_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              reset,
    hamming_decoder_if.slave bus
);

    rx_state_e        state_q;
    logic [3:0]       bit_cnt_q;
    logic [N-2:0]     shift_q;
    codeword_t        hold_q;
    logic             load_q;
    data_t            tx_data_q;
    logic [3:0]       tx_cnt_q;
    logic             tx_sof_q;
    logic             corrected_q;
    logic             frame_abort_q;
    syndrome_t        syndrome_q;
    logic [CNT_W-1:0] err_count_q;

    syndrome_t corr_syndrome;
    data_t     corr_data;

    hamming_corrector u_corrector (
        .codeword (hold_q),
        .syndrome (corr_syndrome),
        .data     (corr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            hold_q        <= '0;
            load_q        <= 1'b0;
            tx_data_q     <= '0;
            tx_cnt_q      <= '0;
            tx_sof_q      <= 1'b0;
            corrected_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            syndrome_q    <= '0;
            err_count_q   <= '0;
        end else begin
            frame_abort_q <= 1'b0;
            load_q        <= 1'b0;
            tx_sof_q      <= 1'b0;
            corrected_q   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (bus.s_valid && bus.s_sof) begin
                        shift_q   <= {{(N-2){1'b0}}, bus.s_in};
                        bit_cnt_q <= 4'd1;
                        state_q   <= StRecv;
                    end
                end
                StRecv: begin
                    if (bus.s_valid) begin
                        if (bus.s_sof) begin
                            // Restart: the current bit becomes position 1 of a new frame.
                            shift_q       <= {{(N-2){1'b0}}, bus.s_in};
                            bit_cnt_q     <= 4'd1;
                            frame_abort_q <= 1'b1;
                        end else if (bit_cnt_q == 4'(N-1)) begin
                            hold_q    <= {bus.s_in, shift_q};
                            load_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            state_q   <= StIdle;
                        end else begin
                            shift_q[bit_cnt_q] <= bus.s_in;
                            bit_cnt_q          <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Transmit path runs one edge behind capture, from the held codeword.
            if (load_q) begin
                tx_data_q   <= corr_data;
                tx_cnt_q    <= 4'(K);
                tx_sof_q    <= 1'b1;
                corrected_q <= (corr_syndrome != '0);
                syndrome_q  <= corr_syndrome;
                if ((corr_syndrome != '0) && (err_count_q != '1)) begin
                    err_count_q <= err_count_q + CNT_W'(1);
                end
            end else if (tx_cnt_q != '0) begin
                tx_data_q <= tx_data_q >> 1;
                tx_cnt_q  <= tx_cnt_q - 4'd1;
            end
        end
    end

    assign bus.s_out       = tx_data_q[0];
    assign bus.s_out_valid = (tx_cnt_q != '0);
    assign bus.s_out_sof   = tx_sof_q;
    assign bus.corrected   = corrected_q;
    assign bus.frame_abort = frame_abort_q;
    assign bus.syndrome    = syndrome_q;
    assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: a cycle-indexed expected-output schedule built
// from injected errors, checked every cycle, plus literal spot checks.
module tb_hamming_decoder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en   = 1'b0;
    bit   in_frame = 1'b0;
    int   total_err = 0;

    bit         exp_out     [int];
    bit         exp_first   [int];
    bit         exp_corr    [int];
    bit         exp_abort   [int];
    bit         exp_rst     [int];
    logic [3:0] exp_syn_upd [int];
    int         exp_cnt_upd [int];

    hamming_decoder_if #(.CNT_W(16)) bus ();
    hamming_decoder_if #(.CNT_W(2))  bus2 ();

    assign bus2.s_in    = bus.s_in;
    assign bus2.s_valid = bus.s_valid;
    assign bus2.s_sof   = bus.s_sof;

    hamming_decoder #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    hamming_decoder #(.CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Position of d[k]: k-th position that is not a power of two.
    function automatic int bench_pos(input int k);
        int cnt;
        cnt = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k) return p;
                cnt++;
            end
        end
        return 0;
    endfunction

    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] cw;
        logic        par;
        cw = '0;
        for (int k = 0; k < 11; k++) cw[bench_pos(k) - 1] = d[k];
        for (int i = 0; i < 4; i++) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if ((p & (1 << i)) != 0) par ^= cw[p - 1];
            end
            cw[(1 << i) - 1] = par;
        end
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [14:0] cw);
        logic [10:0] d;
        for (int k = 0; k < 11; k++) d[k] = cw[bench_pos(k) - 1];
        return d;
    endfunction

    function automatic void clear_from(input int n);
        for (int i = n; i < n + 32; i++) begin
            if (exp_out.exists(i))     exp_out.delete(i);
            if (exp_first.exists(i))   exp_first.delete(i);
            if (exp_corr.exists(i))    exp_corr.delete(i);
            if (exp_abort.exists(i))   exp_abort.delete(i);
            if (exp_syn_upd.exists(i)) exp_syn_upd.delete(i);
            if (exp_cnt_upd.exists(i)) exp_cnt_upd.delete(i);
        end
    endfunction

    task automatic drive(input bit v, input bit sof, input bit b);
        @(negedge clk);
        bus.s_valid = v;
        bus.s_sof   = sof;
        bus.s_in    = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Sends the first nbits of cw; a full frame schedules its expected output window.
    task automatic send(input logic [14:0] cw, input int nbits, input bit gaps,
                        input logic [10:0] d, input logic [3:0] syn);
        int g;
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            drive(1'b1, i == 0, cw[i]);
            if (i == 0) begin
                if (in_frame) exp_abort[cyc + 1] = 1'b1;
                in_frame = 1'b1;
            end
            if (i == 14) begin
                for (int k = 0; k < 11; k++) exp_out[cyc + 2 + k] = d[k];
                exp_first[cyc + 2]   = 1'b1;
                exp_corr[cyc + 2]    = (syn != 4'd0);
                exp_syn_upd[cyc + 2] = syn;
                if (syn != 4'd0) total_err++;
                exp_cnt_upd[cyc + 2] = total_err;
                in_frame = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [10:0] d, input int e1, input int e2, input bit gaps);
        logic [14:0] cw;
        logic [14:0] fix;
        logic [3:0]  syn;
        cw = encode(d);
        if (e1 != 0) cw[e1 - 1] = ~cw[e1 - 1];
        if (e2 != 0) cw[e2 - 1] = ~cw[e2 - 1];
        syn = 4'(e1 ^ e2);
        fix = cw;
        if (syn != 4'd0) fix[syn - 4'd1] = ~fix[syn - 4'd1];
        send(cw, 15, gaps, extract(fix), syn);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_in    = 1'b0;
        clear_from(cyc + 1);
        exp_rst[cyc + 1] = 1'b1;
        total_err = 0;
        in_frame  = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    // Per-cycle compare against the schedule.
    initial begin
        logic [3:0] cur_syn;
        int         cur_cnt;
        int         n;
        bit         v;
        cur_syn = '0;
        cur_cnt = 0;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                n = cyc;
                if (exp_rst.exists(n)) begin
                    cur_syn = '0;
                    cur_cnt = 0;
                end
                if (exp_syn_upd.exists(n)) cur_syn = exp_syn_upd[n];
                if (exp_cnt_upd.exists(n)) cur_cnt = exp_cnt_upd[n];
                v = exp_out.exists(n);
                chk("s_out_valid", bus.s_out_valid, v);
                if (v) chk("s_out", bus.s_out, exp_out[n]);
                chk("s_out_sof", bus.s_out_sof, exp_first.exists(n));
                chk("corrected", bus.corrected, exp_corr.exists(n) ? exp_corr[n] : 1'b0);
                chk("frame_abort", bus.frame_abort, exp_abort.exists(n));
                chk("syndrome", bus.syndrome, cur_syn);
                chk("err_count", bus.err_count, (cur_cnt > 65535) ? 65535 : cur_cnt);
                chk("sat_syndrome", bus2.syndrome, cur_syn);
                chk("sat_err_count", bus2.err_count, (cur_cnt > 3) ? 3 : cur_cnt);
            end
        end
    end

    initial begin
        logic [14:0] cw;
        bus.s_in    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("reset_s_out_valid", bus.s_out_valid, 0);
        chk("reset_syndrome", bus.syndrome, 0);
        chk("reset_err_count", bus.err_count, 0);
        @(negedge clk);
        reset = 1'b0;

        chk("model_encode_d0", encode(11'h001), 32'h0007);
        chk("model_encode_ones", encode(11'h7ff), 32'h7fff);
        chk("model_pos_d10", bench_pos(10), 15);

        // Clean frame.
        run_frame(11'h001, 0, 0, 1'b0);
        idle(14);
        chk("clean_syndrome", bus.syndrome, 0);
        chk("clean_err_count", bus.err_count, 0);

        // Single error at position 3.
        run_frame(11'h001, 3, 0, 1'b0);
        idle(14);
        chk("single_syndrome", bus.syndrome, 3);
        chk("single_err_count", bus.err_count, 1);

        // Error-position sweep.
        for (int p = 1; p <= 15; p++) begin
            run_frame(11'($urandom), p, 0, 1'b0);
            idle(4);
        end
        idle(10);
        chk("sweep_last_syndrome", bus.syndrome, 15);
        chk("sweep_err_count", bus.err_count, 16);
        chk("sweep_sat_count", bus2.err_count, 3);

        // Double error is miscorrected into d[0].
        run_frame(11'h000, 1, 2, 1'b0);
        idle(14);
        chk("double_syndrome", bus.syndrome, 3);

        // Stalled input.
        run_frame(11'h2c3, 6, 0, 1'b1);
        idle(14);
        run_frame(11'h7ff, 0, 0, 1'b1);
        idle(14);

        // Abort after 5 bits, then a full frame; then stray bits while idle.
        send(encode(11'h155), 5, 1'b0, '0, '0);
        run_frame(11'h5a5, 11, 0, 1'b0);
        repeat (5) drive(1'b1, 1'b0, 1'b1);
        idle(14);

        // Back-to-back frames.
        run_frame(11'h123, 0, 0, 1'b0);
        run_frame(11'h456, 9, 0, 1'b0);
        run_frame(11'h789, 0, 0, 1'b0);
        idle(14);

        // Reset during transmission and mid-frame, then trailing non-sof bits.
        run_frame(11'h3ff, 0, 0, 1'b0);
        send(encode(11'h0f0), 7, 1'b0, '0, '0);
        do_reset(2);
        repeat (8) drive(1'b1, 1'b0, 1'b1);
        idle(14);
        chk("post_reset_syndrome", bus.syndrome, 0);
        chk("post_reset_err_count", bus.err_count, 0);
        chk("post_reset_valid", bus.s_out_valid, 0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 5; i++) begin
            run_frame(11'($urandom), 1 + (i * 3), 0, 1'b0);
            idle(4);
        end
        idle(10);
        chk("sat_five_frames", bus2.err_count, 3);
        chk("wide_five_frames", bus.err_count, 5);

        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
